// File: rtl/line_mem_responder_pkg.sv
// Shared memory-message types for 16-byte line transfers, plus the
// len-to-byte-enable decode used by anything that writes partial lines.
package line_mem_responder_pkg;

  localparam int unsigned MemLineBytes = 16;

  localparam logic [2:0] MemTypeRead  = 3'd0;
  localparam logic [2:0] MemTypeWrite = 3'd1;
  localparam logic [2:0] MemTypeInit  = 3'd2;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

  // len==0 means a full line; otherwise the low len bytes.
  function automatic logic [MemLineBytes-1:0] len_to_byte_en(input logic [3:0] len);
    if (len == 4'd0) return '1;
    return (16'd1 << len) - 16'd1;
  endfunction

endpackage

// File: rtl/line_mem_responder_line_store.sv
// Line storage: one combinational read port, one synchronous byte-enabled write port.
// Contents are deliberately not reset.
module line_store
  import line_mem_responder_pkg::*;
#(
  parameter int unsigned p_num_lines = 16,
  localparam int unsigned IdxW = $clog2(p_num_lines)
) (
  input  logic                    clk,
  input  logic [IdxW-1:0]         rd_idx,
  output logic [127:0]            rd_data,
  input  logic                    wr_en,
  input  logic [IdxW-1:0]         wr_idx,
  input  logic [MemLineBytes-1:0] wr_be,
  input  logic [127:0]            wr_data
);

  logic [127:0] mem [p_num_lines];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < MemLineBytes; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Single-outstanding memory responder: accepts one line request, answers it
// after a fixed latency, and holds the response until the cache takes it.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int unsigned p_num_lines = 16,
  parameter int unsigned p_latency   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  logic [174:0] memreq_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output logic [144:0] memresp_msg
);

  localparam int unsigned IdxW    = $clog2(p_num_lines);
  localparam logic [3:0]  LatLoad = 4'(p_latency - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  mem_resp_16B_t resp_q, resp_d;

  mem_req_16B_t  req;
  logic          req_go;
  logic          wr_en;
  logic [127:0]  rd_data;

  assign req         = mem_req_16B_t'(memreq_msg);
  assign memreq_rdy  = (state_q == StIdle) && !reset;
  assign memresp_val = (state_q == StResp) && !reset;
  assign memresp_msg = resp_q;
  assign req_go      = memreq_val && memreq_rdy;
  assign wr_en       = req_go && (req.msg_type == MemTypeWrite || req.msg_type == MemTypeInit);

  line_store #(
    .p_num_lines(p_num_lines)
  ) u_store (
    .clk    (clk),
    .rd_idx (req.addr[4 +: IdxW]),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_idx (req.addr[4 +: IdxW]),
    .wr_be  (len_to_byte_en(req.len)),
    .wr_data(req.data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    unique case (state_q)
      StIdle: begin
        if (req_go) begin
          // Read data is taken before the same-edge write lands.
          resp_d.msg_type = req.msg_type;
          resp_d.opaque   = req.opaque;
          resp_d.test     = 2'b00;
          resp_d.len      = req.len;
          resp_d.data     = (req.msg_type == MemTypeRead) ? rd_data : '0;
          if (p_latency == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatLoad;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StResp;
      end
      StResp: begin
        if (memresp_val && memresp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized bench for line_mem_responder against a byte-level array model.
module tb_line_mem_responder;

  localparam int unsigned Lat   = 2;
  localparam int unsigned Lines = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         memreq_val;
  logic         memreq_rdy;
  logic [174:0] memreq_msg;
  logic         memresp_val;
  logic         memresp_rdy;
  logic [144:0] memresp_msg;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] ref_mem [Lines];

  always #5 clk = ~clk;

  line_mem_responder #(
    .p_num_lines(Lines),
    .p_latency  (Lat)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memreq_val (memreq_val),
    .memreq_rdy (memreq_rdy),
    .memreq_msg (memreq_msg),
    .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy),
    .memresp_msg(memresp_msg)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full request/response exchange; the model predicts the response.
  task automatic xact(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                      input logic [3:0] ln, input logic [127:0] d, input int stall,
                      output logic [127:0] got);
    logic [3:0]   idx;
    logic [127:0] exp_data;
    logic [144:0] exp_msg;
    logic [144:0] held;
    logic         bad;
    int           n;
    idx      = a[7:4];
    exp_data = (t == 3'd0) ? ref_mem[idx] : '0;
    if (t == 3'd1 || t == 3'd2) begin
      for (int b = 0; b < 16; b++) begin
        if (ln == 4'd0 || b < int'(ln)) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    exp_msg = {t, op, 2'b00, ln, exp_data};

    @(negedge clk);
    check_eq("req_rdy_idle", 256'(memreq_rdy), 256'(1));
    memreq_val = 1'b1;
    memreq_msg = {t, op, a, ln, d};
    @(negedge clk);
    memreq_val = 1'b0;
    memreq_msg = 175'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});

    n   = 1;
    bad = 1'b0;
    while (!memresp_val && n < 40) begin
      if (memreq_rdy) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check_eq("latency", 256'(n), 256'(Lat));
    check_eq("wait_req_rdy", 256'(bad), 256'(0));

    held = memresp_msg;
    if (stall > 0) begin
      bad = 1'b0;
      for (int i = 0; i < stall; i++) begin
        if (!memresp_val || memresp_msg !== held || memreq_rdy) bad = 1'b1;
        @(negedge clk);
      end
      check_eq("stall_hold", 256'(bad), 256'(0));
    end

    check_eq("resp_msg", 256'(memresp_msg), 256'(exp_msg));
    check_eq("resp_cycle_req_rdy", 256'(memreq_rdy), 256'(0));
    got = memresp_msg[127:0];
    memresp_rdy = 1'b1;
    @(negedge clk);
    memresp_rdy = 1'b0;
    check_eq("resp_done", 256'(memresp_val), 256'(0));
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] d1;
    logic [127:0] w;
    logic         leak;
    int           r;
    logic [2:0]   t;

    reset       = 1'b1;
    memreq_val  = 1'b0;
    memreq_msg  = '0;
    memresp_rdy = 1'b0;

    // Reset: 3 cycles, then ready on the very next cycle.
    @(negedge clk);
    check_eq("rst_req_rdy", 256'(memreq_rdy), 256'(0));
    check_eq("rst_resp_val", 256'(memresp_val), 256'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_rdy", 256'(memreq_rdy), 256'(1));
    check_eq("post_rst_resp_val", 256'(memresp_val), 256'(0));

    for (int i = 0; i < int'(Lines); i++) begin
      xact(3'd2, 8'(i), 32'(i) << 4, 4'd0, {$urandom, $urandom, $urandom, $urandom}, 0, got);
    end

    // Init then read back through a different byte offset in the same line.
    d1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    xact(3'd2, 8'h11, 32'h20, 4'd0, d1, 0, got);
    check_eq("init_data_zero", 256'(got), 256'(0));
    xact(3'd0, 8'h22, 32'h24, 4'd0, '0, 0, got);
    check_eq("read_init_line", 256'(got), 256'(d1));

    xact(3'd1, 8'h33, 32'h20, 4'd4, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF}, 0, got);
    xact(3'd0, 8'h44, 32'h20, 4'd0, '0, 0, got);
    check_eq("partial_write", 256'(got), 256'({d1[127:32], 32'hDEAD_BEEF}));

    xact(3'd0, 8'h55, 32'h20, 4'd0, '0, 5, got);

    w = {$urandom, $urandom, $urandom, $urandom};
    xact(3'd1, 8'h66, 32'h100, 4'd0, w, 0, got);
    xact(3'd0, 8'h77, 32'h000, 4'd0, '0, 0, got);
    check_eq("wrap_read", 256'(got), 256'(w));

    xact(3'd5, 8'h88, 32'h30, 4'd0, {$urandom, $urandom, $urandom, $urandom}, 0, got);
    xact(3'd0, 8'h99, 32'h30, 4'd0, '0, 0, got);

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      t = 3'd0;
      else if (r < 7) t = 3'd1;
      else if (r < 9) t = 3'd2;
      else            t = 3'($urandom_range(3, 7));
      xact(t, 8'($urandom), $urandom, 4'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), got);
    end

    // Reset during WAIT drops the read; storage survives.
    @(negedge clk);
    memreq_val = 1'b1;
    memreq_msg = {3'd0, 8'hAB, 32'h50, 4'd0, 128'h0};
    @(negedge clk);
    memreq_val = 1'b0;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    memresp_rdy = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_req_rdy", 256'(memreq_rdy), 256'(1));
    leak = memresp_val;
    repeat (8) begin
      @(negedge clk);
      if (memresp_val) leak = 1'b1;
    end
    memresp_rdy = 1'b0;
    check_eq("mid_rst_no_resp", 256'(leak), 256'(0));
    xact(3'd0, 8'hCD, 32'h50, 4'd0, '0, 0, got);
    check_eq("mid_rst_data_kept", 256'(got), 256'(ref_mem[5]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
